ram_arbiter: RTL and testbench

- Shares one dev_ram instance between two requesters: client 0 (instruction fetch) and client 1 (load/store unit).
- Grants at most one RAM operation per cycle, using round-robin arbitration.
- Enforces the RAM's one-cycle read latency. After every fetch, the cycle that follows is a dead cycle (op = RAM_NONE). This keeps dev_ram's shift and extend path stable while the read data is consumed.
- Sits between the core's memory clients and the dev_ram server port.

---
 rtl/ram_arbiter.sv | 140 ++++++++++++++
 tb/tb_ram_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter sharing one dev_ram port between fetch and load/store clients
module ram_arbiter #(
    parameter int ADDRW = 17,
    parameter int DATAW = 64
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             c0_req,
    input  logic             c0_we,
    input  logic [ADDRW-1:0] c0_addr,
    input  logic [1:0]       c0_type,
    input  logic [DATAW-1:0] c0_wdata,
    output logic             c0_gnt,
    output logic             c0_rvalid,
    output logic [DATAW-1:0] c0_rdata,

    input  logic             c1_req,
    input  logic             c1_we,
    input  logic [ADDRW-1:0] c1_addr,
    input  logic [1:0]       c1_type,
    input  logic [DATAW-1:0] c1_wdata,
    output logic             c1_gnt,
    output logic             c1_rvalid,
    output logic [DATAW-1:0] c1_rdata,

    output logic [1:0]       ram_op,
    output logic [ADDRW-1:0] ram_addr,
    output logic [1:0]       ram_type,
    output logic [DATAW-1:0] ram_wdata,
    input  logic [DATAW-1:0] ram_rdata,

    output logic             busy
);

    localparam logic [1:0] RAM_NONE  = 2'd0;
    localparam logic [1:0] RAM_FETCH = 2'd1;
    localparam logic [1:0] RAM_STORE = 2'd2;

    typedef enum logic {ISSUE, RESP} state_t;

    state_t           state, state_next;
    logic             rr_last, rr_last_next;
    logic             owner, owner_next;
    logic [1:0]       rvalid_q, rvalid_next;
    logic [DATAW-1:0] hold0, hold1;
    logic             win_valid;
    logic             win;
    logic             win_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ISSUE;
            rr_last  <= 1'b1;
            owner    <= 1'b0;
            rvalid_q <= 2'b00;
            hold0    <= '0;
            hold1    <= '0;
        end else begin
            state    <= state_next;
            rr_last  <= rr_last_next;
            owner    <= owner_next;
            rvalid_q <= rvalid_next;
            // Read data is only on ram_rdata during RESP; keep a copy for the owner.
            if (state == RESP) begin
                if (owner) begin
                    hold1 <= ram_rdata;
                end else begin
                    hold0 <= ram_rdata;
                end
            end
        end
    end

    always_comb begin
        state_next   = state;
        rr_last_next = rr_last;
        owner_next   = owner;
        rvalid_next  = 2'b00;
        win_valid    = 1'b0;
        win          = 1'b0;
        win_we       = 1'b0;
        c0_gnt       = 1'b0;
        c1_gnt       = 1'b0;
        ram_op       = RAM_NONE;
        ram_addr     = '0;
        ram_type     = 2'd0;
        ram_wdata    = '0;
        busy         = 1'b0;

        case (state)
            ISSUE: begin
                if (c0_req && c1_req) begin
                    win_valid = 1'b1;
                    win       = ~rr_last;
                end else if (c0_req) begin
                    win_valid = 1'b1;
                    win       = 1'b0;
                end else if (c1_req) begin
                    win_valid = 1'b1;
                    win       = 1'b1;
                end

                if (win_valid) begin
                    rr_last_next = win;
                    if (win) begin
                        c1_gnt    = 1'b1;
                        win_we    = c1_we;
                        ram_addr  = c1_addr;
                        ram_type  = c1_type;
                        ram_wdata = c1_wdata;
                    end else begin
                        c0_gnt    = 1'b1;
                        win_we    = c0_we;
                        ram_addr  = c0_addr;
                        ram_type  = c0_type;
                        ram_wdata = c0_wdata;
                    end
                    ram_op = win_we ? RAM_STORE : RAM_FETCH;
                    // Fetches need the dead cycle; stores stay in ISSUE for back-to-back use.
                    if (!win_we) begin
                        owner_next       = win;
                        state_next       = RESP;
                        rvalid_next[win] = 1'b1;
                    end
                end
            end
            RESP: begin
                busy       = 1'b1;
                state_next = ISSUE;
            end
        endcase
    end

    assign c0_rvalid = rvalid_q[0];
    assign c1_rvalid = rvalid_q[1];
    assign c0_rdata  = (state == RESP && !owner) ? ram_rdata : hold0;
    assign c1_rdata  = (state == RESP &&  owner) ? ram_rdata : hold1;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with behavioural dev_ram and reference model
module tb_ram_arbiter;

    localparam int ADDRW = 17;
    localparam int DATAW = 64;
    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_FETCH = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [1:0] T_BYTE = 2'd0;
    localparam logic [1:0] T_WORD = 2'd1;
    localparam logic [1:0] T_LONG = 2'd2;
    localparam logic [1:0] T_QUAD = 2'd3;

    logic             clk, rst;
    logic             c0_req, c0_we, c1_req, c1_we;
    logic [ADDRW-1:0] c0_addr, c1_addr;
    logic [1:0]       c0_type, c1_type;
    logic [DATAW-1:0] c0_wdata, c1_wdata;
    logic             c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
    logic [DATAW-1:0] c0_rdata, c1_rdata;
    logic [1:0]       ram_op, ram_type;
    logic [ADDRW-1:0] ram_addr;
    logic [DATAW-1:0] ram_wdata, ram_rdata;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_env [0:131071];
    logic [7:0] mem_mod [0:131071];

    ram_arbiter #(.ADDRW(ADDRW), .DATAW(DATAW)) dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_type(c0_type), .c0_wdata(c0_wdata),
        .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_type(c1_type), .c1_wdata(c1_wdata),
        .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
        .ram_op(ram_op), .ram_addr(ram_addr), .ram_type(ram_type), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Big-endian byte memory; the access size is 1 << type bytes, data right-aligned.
    function automatic logic [63:0] rd_mem(input bit m, input logic [16:0] a, input logic [1:0] t);
        logic [63:0] d;
        int n;
        d = '0;
        n = 1 << t;
        for (int i = 0; i < n; i++) begin
            logic [16:0] ai;
            ai = a + 17'(i);
            d = {d[55:0], (m ? mem_mod[ai] : mem_env[ai])};
        end
        return d;
    endfunction

    task automatic wr_env(input logic [16:0] a, input logic [1:0] t, input logic [63:0] d);
        int n;
        n = 1 << t;
        for (int i = 0; i < n; i++) begin
            logic [16:0] ai;
            ai = a + 17'(i);
            mem_env[ai] = d[(n-1-i)*8 +: 8];
        end
    endtask

    task automatic wr_mod(input logic [16:0] a, input logic [1:0] t, input logic [63:0] d);
        int n;
        n = 1 << t;
        for (int i = 0; i < n; i++) begin
            logic [16:0] ai;
            ai = a + 17'(i);
            mem_mod[ai] = d[(n-1-i)*8 +: 8];
        end
    endtask

    // dev_ram stand-in: one-cycle read latency, garbage on the bus when no fetch was issued.
    always @(posedge clk) begin
        if (ram_op == OP_STORE) wr_env(ram_addr, ram_type, ram_wdata);
        if (ram_op == OP_FETCH) ram_rdata <= rd_mem(1'b0, ram_addr, ram_type);
        else                    ram_rdata <= {$urandom, $urandom};
    end

    // A request must stay up until it is granted.
    logic pend0, pend1;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
        end else begin
            if (pend0) assert (c0_req) else $error("FAIL protocol c0 request dropped before grant");
            if (pend1) assert (c1_req) else $error("FAIL protocol c1 request dropped before grant");
            pend0 <= c0_req && !c0_gnt;
            pend1 <= c1_req && !c1_gnt;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input int n, input logic r, input logic we, input logic [16:0] a,
                         input logic [1:0] t, input logic [63:0] d);
        if (n == 0) begin
            c0_req = r; c0_we = we; c0_addr = a; c0_type = t; c0_wdata = d;
        end else begin
            c1_req = r; c1_we = we; c1_addr = a; c1_type = t; c1_wdata = d;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0, T_BYTE, '0);
        drive(1, 1'b0, 1'b0, '0, T_BYTE, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit         rst_before;
        bit         r0, w0, r1, w1;
        bit         g0, g1;
        logic [1:0] op;
        bit         bsy, v0, v1;
    } vec_t;

    function automatic vec_t mk(input logic [11:0] c);
        vec_t v;
        v.rst_before = c[11];
        v.r0 = c[10]; v.w0 = c[9]; v.r1 = c[8]; v.w1 = c[7];
        v.g0 = c[6];  v.g1 = c[5];
        v.op = c[4:3];
        v.bsy = c[2]; v.v0 = c[1]; v.v1 = c[0];
        return v;
    endfunction

    vec_t tbl [16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // {rst, r0 w0 r1 w1, g0 g1, op, busy, v0 v1}
        tbl[0]  = mk(12'b1_1010_10_01_0_00);
        tbl[1]  = mk(12'b0_1010_00_00_1_10);
        tbl[2]  = mk(12'b0_1010_01_01_0_00);
        tbl[3]  = mk(12'b0_1010_00_00_1_01);
        tbl[4]  = mk(12'b0_1010_10_01_0_00);
        tbl[5]  = mk(12'b0_1010_00_00_1_10);
        tbl[6]  = mk(12'b0_1010_01_01_0_00);
        tbl[7]  = mk(12'b0_1010_00_00_1_01);
        tbl[8]  = mk(12'b1_1111_10_10_0_00);
        tbl[9]  = mk(12'b0_1111_01_10_0_00);
        tbl[10] = mk(12'b0_1100_10_10_0_00);
        tbl[11] = mk(12'b0_0000_00_00_0_00);
        tbl[12] = mk(12'b0_0010_01_01_0_00);
        tbl[13] = mk(12'b0_1100_00_00_1_01);
        tbl[14] = mk(12'b0_1100_10_10_0_00);
        tbl[15] = mk(12'b0_0011_01_10_0_00);

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0, T_BYTE, '0);
        drive(1, 1'b0, 1'b0, '0, T_BYTE, '0);
        #2;
        chk("reset_c0_gnt", 64'(c0_gnt), 64'd0);
        chk("reset_c1_gnt", 64'(c1_gnt), 64'd0);
        chk("reset_c0_rvalid", 64'(c0_rvalid), 64'd0);
        chk("reset_c1_rvalid", 64'(c1_rvalid), 64'd0);
        chk("reset_c0_rdata", c0_rdata, 64'd0);
        chk("reset_c1_rdata", c1_rdata, 64'd0);
        chk("reset_ram_op", 64'(ram_op), 64'(OP_NONE));
        chk("reset_ram_addr", 64'(ram_addr), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);

        // Arbitration table
        for (int i = 0; i < 16; i++) begin
            logic [63:0] exp_addr;
            if (tbl[i].rst_before) do_reset();
            drive(0, tbl[i].r0, tbl[i].w0, 17'h100, T_QUAD, 64'hC0C0_0000_0000_0000 | 64'(i));
            drive(1, tbl[i].r1, tbl[i].w1, 17'h200, T_QUAD, 64'hC1C1_0000_0000_0000 | 64'(i));
            smp();
            exp_addr = tbl[i].g0 ? 64'h100 : (tbl[i].g1 ? 64'h200 : 64'h0);
            chk($sformatf("tbl%0d_c0_gnt", i), 64'(c0_gnt), 64'(tbl[i].g0));
            chk($sformatf("tbl%0d_c1_gnt", i), 64'(c1_gnt), 64'(tbl[i].g1));
            chk($sformatf("tbl%0d_ram_op", i), 64'(ram_op), 64'(tbl[i].op));
            chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].bsy));
            chk($sformatf("tbl%0d_c0_rvalid", i), 64'(c0_rvalid), 64'(tbl[i].v0));
            chk($sformatf("tbl%0d_c1_rvalid", i), 64'(c1_rvalid), 64'(tbl[i].v1));
            chk($sformatf("tbl%0d_ram_addr", i), 64'(ram_addr), exp_addr);
            step();
        end

        // Single fetch with held read data
        do_reset();
        drive(0, 1'b1, 1'b1, 17'h10, T_QUAD, 64'h1122334455667788);
        smp();
        chk("A_pre_store_gnt", 64'(c0_gnt), 64'd1);
        chk("A_pre_store_op", 64'(ram_op), 64'(OP_STORE));
        step();
        drive(0, 1'b1, 1'b0, 17'h10, T_QUAD, '0);
        smp();
        chk("A_t0_gnt", 64'(c0_gnt), 64'd1);
        chk("A_t0_op", 64'(ram_op), 64'(OP_FETCH));
        chk("A_t0_addr", 64'(ram_addr), 64'h10);
        step();
        drive(0, 1'b0, 1'b0, '0, T_BYTE, '0);
        smp();
        chk("A_t1_op", 64'(ram_op), 64'(OP_NONE));
        chk("A_t1_rvalid", 64'(c0_rvalid), 64'd1);
        chk("A_t1_rdata", c0_rdata, 64'h1122334455667788);
        chk("A_t1_busy", 64'(busy), 64'd1);
        chk("A_t1_c1_rvalid", 64'(c1_rvalid), 64'd0);
        repeat (4) begin
            step();
            smp();
        end
        chk("A_t5_rdata", c0_rdata, 64'h1122334455667788);
        chk("A_t5_rvalid", 64'(c0_rvalid), 64'd0);

        // Back-to-back stores then read-back
        step();
        drive(1, 1'b1, 1'b1, 17'h23, T_BYTE, 64'hAB);
        smp();
        chk("B_t0_gnt", 64'(c1_gnt), 64'd1);
        chk("B_t0_op", 64'(ram_op), 64'(OP_STORE));
        step();
        drive(1, 1'b1, 1'b1, 17'h40, T_WORD, 64'hBEEF);
        smp();
        chk("B_t1_gnt", 64'(c1_gnt), 64'd1);
        chk("B_t1_op", 64'(ram_op), 64'(OP_STORE));
        chk("B_t1_addr", 64'(ram_addr), 64'h40);
        step();
        drive(1, 1'b1, 1'b0, 17'h23, T_BYTE, '0);
        smp();
        chk("B_fetch_gnt", 64'(c1_gnt), 64'd1);
        step();
        drive(1, 1'b0, 1'b0, '0, T_BYTE, '0);
        smp();
        chk("B_byte_rvalid", 64'(c1_rvalid), 64'd1);
        chk("B_byte_rdata", c1_rdata, 64'h00000000000000AB);
        step();
        drive(1, 1'b1, 1'b0, 17'h40, T_WORD, '0);
        smp();
        step();
        drive(1, 1'b0, 1'b0, '0, T_BYTE, '0);
        smp();
        chk("B_word_rdata", c1_rdata, 64'h000000000000BEEF);
        chk("B_c0_untouched", c0_rdata, 64'h1122334455667788);

        // Request raised during RESP waits for next ISSUE
        step();
        drive(0, 1'b1, 1'b0, 17'h23, T_BYTE, '0);
        smp();
        chk("C_t0_c0_gnt", 64'(c0_gnt), 64'd1);
        step();
        drive(0, 1'b0, 1'b0, '0, T_BYTE, '0);
        drive(1, 1'b1, 1'b1, 17'h50, T_LONG, 64'hCAFEF00D);
        smp();
        chk("C_t1_c1_gnt", 64'(c1_gnt), 64'd0);
        chk("C_t1_busy", 64'(busy), 64'd1);
        step();
        smp();
        chk("C_t2_c1_gnt", 64'(c1_gnt), 64'd1);
        chk("C_t2_op", 64'(ram_op), 64'(OP_STORE));
        step();
        drive(1, 1'b0, 1'b0, '0, T_BYTE, '0);

        // Asynchronous reset during RESP
        drive(0, 1'b1, 1'b0, 17'h10, T_QUAD, '0);
        smp();
        chk("D_t0_gnt", 64'(c0_gnt), 64'd1);
        step();
        drive(0, 1'b0, 1'b0, '0, T_BYTE, '0);
        smp();
        chk("D_t1_rdata", c0_rdata, 64'h1122334455667788);
        #1 rst = 1'b1;
        #1;
        chk("D_rst_c0_rvalid", 64'(c0_rvalid), 64'd0);
        chk("D_rst_c0_rdata", c0_rdata, 64'd0);
        chk("D_rst_c1_rdata", c1_rdata, 64'd0);
        chk("D_rst_op", 64'(ram_op), 64'(OP_NONE));
        chk("D_rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 17'h10, T_QUAD, '0);
        drive(1, 1'b1, 1'b0, 17'h40, T_WORD, '0);
        #1;
        chk("D_post_c0_gnt", 64'(c0_gnt), 64'd1);
        chk("D_post_c1_gnt", 64'(c1_gnt), 64'd0);
        step();
        drive(0, 1'b0, 1'b0, '0, T_BYTE, '0);
        smp();
        chk("D_post_c0_rvalid", 64'(c0_rvalid), 64'd1);
        step();
        smp();
        chk("D_post_c1_gnt2", 64'(c1_gnt), 64'd1);
        step();
        drive(1, 1'b0, 1'b0, '0, T_BYTE, '0);
        step();

        // Randomized traffic against the reference model
        do_reset();
        for (int a = 0; a < 131072; a++) mem_mod[a] = mem_env[a];
        begin
            bit          m_resp, m_owner, m_rr;
            logic [63:0] m_data;
            logic [63:0] m_hold [2];
            bit          pend [2];
            bit          q_we [2];
            logic [16:0] q_addr [2];
            logic [1:0]  q_type [2];
            logic [63:0] q_wdata [2];
            m_resp = 0; m_owner = 0; m_rr = 1; m_data = '0;
            m_hold[0] = '0; m_hold[1] = '0;
            pend[0] = 0; pend[1] = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                logic [1:0]  e_gnt, e_rv, e_op, e_type;
                logic [63:0] e_addr, e_wdata, e_rd0, e_rd1;
                bit          e_busy;
                for (int n = 0; n < 2; n++) begin
                    if (!pend[n] && $urandom_range(0, 2) != 0) begin
                        pend[n]    = 1;
                        q_we[n]    = 1'($urandom_range(0, 1));
                        q_addr[n]  = 17'($urandom_range(0, 63));
                        q_type[n]  = 2'($urandom_range(0, 3));
                        q_wdata[n] = {$urandom, $urandom};
                    end
                    if (pend[n]) drive(n, 1'b1, q_we[n], q_addr[n], q_type[n], q_wdata[n]);
                    else         drive(n, 1'b0, 1'b0, '0, T_BYTE, '0);
                end
                smp();
                e_gnt = 2'b00; e_op = OP_NONE; e_addr = '0; e_type = '0; e_wdata = '0;
                e_busy = m_resp;
                e_rv  = m_resp ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
                e_rd0 = (m_resp && !m_owner) ? m_data : m_hold[0];
                e_rd1 = (m_resp &&  m_owner) ? m_data : m_hold[1];
                if (m_resp) begin
                    m_hold[m_owner] = m_data;
                    m_resp = 0;
                end else if (pend[0] || pend[1]) begin
                    bit w;
                    w = (pend[0] && pend[1]) ? !m_rr : pend[1];
                    e_gnt   = w ? 2'b10 : 2'b01;
                    e_op    = q_we[w] ? OP_STORE : OP_FETCH;
                    e_addr  = 64'(q_addr[w]);
                    e_type  = q_type[w];
                    e_wdata = q_wdata[w];
                    if (q_we[w]) wr_mod(q_addr[w], q_type[w], q_wdata[w]);
                    else begin
                        m_data  = rd_mem(1'b1, q_addr[w], q_type[w]);
                        m_resp  = 1;
                        m_owner = w;
                    end
                    m_rr    = w;
                    pend[w] = 0;
                end
                chk("rnd_gnt", 64'({c1_gnt, c0_gnt}), 64'(e_gnt));
                chk("rnd_op", 64'(ram_op), 64'(e_op));
                chk("rnd_addr", 64'(ram_addr), e_addr);
                chk("rnd_type", 64'(ram_type), 64'(e_type));
                chk("rnd_wdata", ram_wdata, e_wdata);
                chk("rnd_busy", 64'(busy), 64'(e_busy));
                chk("rnd_rvalid", 64'({c1_rvalid, c0_rvalid}), 64'(e_rv));
                chk("rnd_c0_rdata", c0_rdata, e_rd0);
                chk("rnd_c1_rdata", c1_rdata, e_rd1);
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
